// File: rtl/Mux3Type.sv
// Shared operand-mux select encoding used by the EX-stage three-input muxes.
// The encoding is fixed: other datapath blocks decode these values directly.
package Mux3Type;

    typedef enum logic [1:0] {
        DEFAULT = 2'b00,  // register-file value
        LEFT    = 2'b01,  // MEM-stage result (top_line)
        RIGHT   = 2'b10,  // WB-stage result (bottom_line)
        ZERO    = 2'b11   // constant 0
    } cmd_t;

endpackage

// File: rtl/forward_ctrl_pkg.sv
// Types and helpers shared by the forwarding controller and its select logic.
// Pipeline shadow entries carry only what forwarding needs to know about a producer.
package forward_ctrl_pkg;

    localparam int FWD_REG_W = 5;
    localparam int FWD_CNT_W = 16;

    typedef logic [FWD_REG_W-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     wen;
        logic     load;
    } fwd_entry_t;

    // WB results are already visible through the write-before-read register file.
    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     wen;
    } wb_entry_t;

    // x0 is hard-wired, so a producer targeting it never supplies a value.
    function automatic logic entry_writes(input fwd_entry_t e, input reg_idx_t r);
        return e.valid && e.wen && (e.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/forward_ctrl_fwd_select.sv
// Operand-mux select for one source register, resolved against the EX and MEM producers.
// The EX producer is checked first because it is the youngest writer of the register.
module fwd_select
    import Mux3Type::*;
    import forward_ctrl_pkg::*;
(
    input  reg_idx_t   i_src,
    input  logic       i_used,
    input  fwd_entry_t i_ex,
    input  fwd_entry_t i_mem,
    output cmd_t       o_cmd
);

    always_comb begin
        // NOTE: default first so every path assigns o_cmd and no latch is inferred.
        o_cmd = DEFAULT;
        if (i_used) begin
            if (i_src == '0)
                o_cmd = ZERO;
            else if (entry_writes(i_ex, i_src))
                o_cmd = LEFT;
            else if (entry_writes(i_mem, i_src))
                o_cmd = RIGHT;
        end
    end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard controller for the EX-stage operand muxes.
// Shadows EX/MEM/WB producers and registers the rs1/rs2 selects as the instruction enters EX.
module forward_ctrl
    import Mux3Type::*;
    import forward_ctrl_pkg::*;
#(
    parameter int REG_W = FWD_REG_W,
    parameter int CNT_W = FWD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             hold,
    output logic             id_stall,
    output cmd_t             ex_rs1_cmd,
    output cmd_t             ex_rs2_cmd,
    output logic [CNT_W-1:0] stall_count
);

    fwd_entry_t       r_ex;
    fwd_entry_t       r_mem;
    wb_entry_t        r_wb;
    cmd_t             r_rs1_cmd;
    cmd_t             r_rs2_cmd;
    logic [CNT_W-1:0] r_stall_count;

    reg_idx_t   w_rs1;
    reg_idx_t   w_rs2;
    fwd_entry_t w_id_entry;
    cmd_t       w_rs1_sel;
    cmd_t       w_rs2_sel;
    logic       w_hazard;
    logic       w_issue;

    assign w_rs1      = reg_idx_t'(id_rs1);
    assign w_rs2      = reg_idx_t'(id_rs2);
    assign w_id_entry = '{valid: 1'b1, rd: reg_idx_t'(id_rd), wen: id_reg_write, load: id_is_load};

    // A load in EX has no result to forward until it reaches WB, one cycle too late.
    assign w_hazard = id_valid && r_ex.load &&
                      ((id_rs1_used && entry_writes(r_ex, w_rs1)) ||
                       (id_rs2_used && entry_writes(r_ex, w_rs2)));
    assign id_stall = w_hazard && !flush;
    assign w_issue  = id_valid && !w_hazard && !flush;

    fwd_select u_sel_rs1 (
        .i_src  (w_rs1),
        .i_used (id_rs1_used),
        .i_ex   (r_ex),
        .i_mem  (r_mem),
        .o_cmd  (w_rs1_sel)
    );

    fwd_select u_sel_rs2 (
        .i_src  (w_rs2),
        .i_used (id_rs2_used),
        .i_ex   (r_ex),
        .i_mem  (r_mem),
        .o_cmd  (w_rs2_sel)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every stage shifts from pre-edge values.
        if (reset) begin
            r_ex          <= '0;
            r_mem         <= '0;
            r_wb          <= '0;
            r_rs1_cmd     <= DEFAULT;
            r_rs2_cmd     <= DEFAULT;
            r_stall_count <= '0;
        end else if (!hold) begin
            r_wb  <= '{valid: r_mem.valid, rd: r_mem.rd, wen: r_mem.wen};
            r_mem <= r_ex;
            if (w_issue) begin
                r_ex      <= w_id_entry;
                r_rs1_cmd <= w_rs1_sel;
                r_rs2_cmd <= w_rs2_sel;
            end else begin
                r_ex      <= '0;
                r_rs1_cmd <= DEFAULT;
                r_rs2_cmd <= DEFAULT;
            end
            if (id_stall && !(&r_stall_count))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign ex_rs1_cmd  = r_rs1_cmd;
    assign ex_rs2_cmd  = r_rs2_cmd;
    assign stall_count = r_stall_count;

    // A RIGHT select means the producer has just moved into WB; LEFT means it sits in MEM.
    a_right_has_wb_producer: assert property (@(posedge clk) disable iff (reset)
        (r_ex.valid && (r_rs1_cmd == RIGHT || r_rs2_cmd == RIGHT))
            |-> (r_wb.valid && r_wb.wen && r_wb.rd != '0));

    a_left_has_mem_producer: assert property (@(posedge clk) disable iff (reset)
        (r_ex.valid && (r_rs1_cmd == LEFT || r_rs2_cmd == LEFT))
            |-> (r_mem.valid && r_mem.wen && r_mem.rd != '0));

endmodule

// File: doc/forward_ctrl.md
# forward_ctrl

Forwarding and hazard controller driving the select inputs of the EX-stage operand muxes. It shadows the rd/write-enable/is-load state of the instructions in EX, MEM and WB. For each instruction issued from ID, it computes a registered `Mux3Type::cmd_t` for rs1 and rs2, and raises a load-use stall when forwarding cannot cover the dependency. Operand-mux convention: `DEFAULT` is the register-file value, `LEFT` (top_line) is the MEM-stage result, `RIGHT` (bottom_line) is the WB-stage result, and `ZERO` is constant 0.

## Interface
- `REG_W`, 5 — register index width.
- `CNT_W`, 16 — width of the load-use stall counter.

- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `id_valid` in 1 — the ID stage holds a real instruction.
- `id_rs1`, `id_rs2` in REG_W — source register indices.
- `id_rs1_used`, `id_rs2_used` in 1 — the instruction reads that source.
- `id_rd` in REG_W — destination register index.
- `id_reg_write` in 1 — the instruction writes `id_rd`.
- `id_is_load` in 1 — the instruction is a load (result available only at WB).
- `flush` in 1 — kill the ID instruction; it does not enter EX.
- `hold` in 1 — external pipeline freeze; all state holds.
- `id_stall` out 1 — load-use hazard; ID must not advance (combinational).
- `ex_rs1_cmd`, `ex_rs2_cmd` out `cmd_t` — operand mux selects for the instruction now in EX (registered).
- `stall_count` out CNT_W — saturating count of cycles with `id_stall` asserted and `hold` low.

## Operation
- The block keeps three shadow entries: EX {valid, rd, wen, load}, MEM {valid, rd, wen, load} and WB {valid, rd, wen}.
- An entry "writes r" when valid && wen && rd == r && r != 0.
- Hazard detection: `hazard` = id_valid && EX writes r && EX.load, for any used source r ∈ {rs1, rs2}.
- Stall output: `id_stall` = hazard && !flush.
- Issue is `issue` = id_valid && !hazard && !flush.
- Select computation, per used source r, evaluated in ID and stored into EX:
  - If the source is unused → `DEFAULT`.
  - Else if r == 0 → `ZERO`.
  - Else if the EX entry writes r → `LEFT`. That producer is in MEM while the consumer is in EX.
  - Else if the MEM entry writes r → `RIGHT`.
  - Else → `DEFAULT`.
  - The EX match has priority over the MEM match, so the youngest producer wins.
- The WB entry never needs forwarding. The register file is write-before-read, so an ID read in the same cycle as the WB write already sees the new value. WB is tracked only so `RIGHT` can be validated in assertions.
- Advance, when `hold` is low:
  - WB ← MEM.
  - MEM ← EX.
  - EX ← the issued instruction if `issue`, otherwise a bubble (valid=0, both cmds `DEFAULT`).
- With `hold` high: no register changes, `stall_count` does not increment, and `id_stall` is still driven combinationally.
- `stall_count` increments when `id_stall` && !`hold`, and saturates at all-ones.

## Timing
- `reset`, sampled at the clock edge:
  - All entries become invalid.
  - `ex_rs1_cmd` and `ex_rs2_cmd` become `DEFAULT`.
  - `stall_count` becomes 0.
  - `id_stall` is 0 in the following cycle, since EX is invalid.
  - Reset overrides `hold` and `flush`.
- Latency: the selects are valid in the cycle immediately after the issuing edge, i.e. the cycle the instruction sits in EX.
- Load-use timing: exactly one stall cycle. The load moves to MEM and a bubble enters EX. On the next cycle the consumer re-evaluates against MEM, which now holds the load, and receives `RIGHT`.
- Simultaneous `flush` and hazard: `flush` wins. `id_stall` = 0, a bubble enters EX, and the counter does not increment.
- Simultaneous `hold` and `flush`: `hold` wins. Nothing advances, and the flush takes effect on the first cycle `hold` is low if it is still asserted.
- rs1 == rs2: both selects are computed identically and independently.
- rd == 0 producers never match, so writes to x0 are never forwarded.

## Structure
- Shared package: `cmd_t` comes from the existing `Mux3Type` package; its encoding is unchanged.
- New package items:
  - register index typedef `reg_idx_t` (REG_W bits);
  - `fwd_entry_t` struct {valid, rd, wen, load}.
- One natural sub-module, `fwd_select`: combinational, taking one source index, the used flag and the EX/MEM entries, and returning a `cmd_t`. It is instantiated twice, once for rs1 and once for rs2.

## Test plan
- ALU chain: `add x5` then `add x6, x5, x5` back-to-back → second instruction gets rs1 = rs2 = `LEFT` and `id_stall` never asserts.
- Distance-2 dependency: `add x7`, an unrelated instruction, then a reader of x7 → rs1 = `RIGHT`. With distance 3 the result is `DEFAULT`.
- Load-use: `lw x8` then `add x9, x8, x1` → `id_stall` high for exactly 1 cycle, a bubble appears in EX, then rs1 = `RIGHT` and rs2 = `DEFAULT`. `stall_count` goes 0→1.
- x0 source, and a producer writing x0 followed by a reader of x0 → the reader's select is `ZERO`, never `LEFT` or `RIGHT`.
- Flush during a load-use hazard → `id_stall` = 0, a bubble enters EX, `stall_count` is unchanged. With `hold` held high for 3 cycles, all outputs stay frozen.
- Reset mid-stream, with entries valid and a stall pending → the next cycle shows `DEFAULT`/`DEFAULT`, `id_stall` = 0 and `stall_count` = 0. Counter saturation: forcing 2^CNT_W stall cycles leaves the count at all-ones.
